// File: rtl/melody_recall_engine.sv
// Memory-game sequencer: plays a growing prefix of a stored melody on a tick
// schedule, then checks the player's answers note by note.
module melody_recall_engine #(
    parameter int NOTE_W        = 4,
    parameter int MAX_NOTES     = 8,
    parameter int START_LEN     = 3,
    parameter int TICK_DIV      = 5000000,
    parameter int ON_TICKS      = 3,
    parameter int GAP_TICKS     = 1,
    parameter int TIMEOUT_TICKS = 10,
    localparam int IDX_W        = $clog2(MAX_NOTES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [NOTE_W-1:0] load_data,
    input  logic              seq_clear,
    input  logic              start,
    input  logic              abort,
    input  logic              strict,
    input  logic              ans_valid,
    input  logic [NOTE_W-1:0] ans_data,
    output logic [NOTE_W-1:0] note_out,
    output logic              note_active,
    output logic [IDX_W-1:0]  seq_len,
    output logic [IDX_W-1:0]  round_len,
    output logic [7:0]        score,
    output logic [2:0]        state_out,
    output logic              miss,
    output logic              round_pass,
    output logic              game_won,
    output logic              busy
);

    localparam int AW    = $clog2(MAX_NOTES);
    localparam int PS_W  = $clog2(TICK_DIV);
    localparam int TMAX1 = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int TMAX  = (TMAX1 > TIMEOUT_TICKS) ? TMAX1 : TIMEOUT_TICKS;
    localparam int TT_W  = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PLAY_ON  = 3'd1,
        S_PLAY_GAP = 3'd2,
        S_WAIT_IN  = 3'd3,
        S_FAIL     = 3'd4,
        S_WIN      = 3'd5
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t              state_q, state_d;
    logic [NOTE_W-1:0]   mem [0:MAX_NOTES-1];
    logic [PS_W-1:0]     ps_cnt;
    logic [TT_W-1:0]     tk_cnt;
    logic                tick, tmr_clr, ans_ok;
    logic                on_done, gap_done, to_done, last;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pre_gap_q, pre_gap_d;
    logic [IDX_W-1:0]    round_len_d, seq_len_d;
    logic [7:0]          score_d;
    logic                mem_we;
    logic                miss_d, pass_d, won_d;
    logic [NOTE_W-1:0]   cur_note, note_d;
    logic                active_d;

    assign tick     = (ps_cnt == PS_W'(TICK_DIV - 1));
    assign on_done  = tick && (tk_cnt == TT_W'(ON_TICKS - 1));
    assign gap_done = tick && (tk_cnt == TT_W'(GAP_TICKS - 1));
    assign to_done  = tick && (tk_cnt == TT_W'(TIMEOUT_TICKS - 1));
    assign last     = (idx_q == round_len - IDX_W'(1));
    assign cur_note = mem[idx_q[AW-1:0]];
    assign ans_ok   = (state_q == S_WAIT_IN) && ans_valid && !abort;
    // Timing restarts on every state entry and on every accepted answer.
    assign tmr_clr  = (state_d != state_q) || ans_ok;
    assign state_out = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_cnt <= '0;
            tk_cnt <= '0;
        end else if (tmr_clr) begin
            ps_cnt <= '0;
            tk_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
            tk_cnt <= tk_cnt + TT_W'(1);
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[seq_len[AW-1:0]] <= load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            pre_gap_q <= 1'b0;
            seq_len   <= '0;
            round_len <= IDX_W'(START_LEN);
            score     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pre_gap_q <= pre_gap_d;
            seq_len   <= seq_len_d;
            round_len <= round_len_d;
            score     <= score_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pre_gap_d   = pre_gap_q;
        seq_len_d   = seq_len;
        round_len_d = round_len;
        score_d     = score;
        mem_we      = 1'b0;
        miss_d      = 1'b0;
        pass_d      = 1'b0;
        won_d       = 1'b0;
        if (abort) begin
            state_d   = S_IDLE;
            idx_d     = '0;
            pre_gap_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && (seq_len >= IDX_W'(START_LEN))) begin
                        round_len_d = IDX_W'(START_LEN);
                        score_d     = '0;
                        idx_d       = '0;
                        state_d     = S_PLAY_ON;
                    end else if (seq_clear) begin
                        seq_len_d = '0;
                    end else if (load_valid && (seq_len < IDX_W'(MAX_NOTES)) &&
                                 (load_data != '0)) begin
                        mem_we    = 1'b1;
                        seq_len_d = seq_len + IDX_W'(1);
                    end
                end
                S_PLAY_ON: begin
                    if (on_done)
                        state_d = S_PLAY_GAP;
                end
                S_PLAY_GAP: begin
                    if (gap_done) begin
                        // A lead-in gap before a replay must not advance idx.
                        if (pre_gap_q) begin
                            pre_gap_d = 1'b0;
                            state_d   = S_PLAY_ON;
                        end else if (last) begin
                            idx_d   = '0;
                            state_d = S_WAIT_IN;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = S_PLAY_ON;
                        end
                    end
                end
                S_WAIT_IN: begin
                    if (ans_valid) begin
                        if (ans_data != cur_note) begin
                            miss_d  = 1'b1;
                            state_d = S_FAIL;
                        end else if (!last) begin
                            idx_d = idx_q + IDX_W'(1);
                        end else begin
                            pass_d  = 1'b1;
                            score_d = sat_inc(score);
                            if (round_len == seq_len) begin
                                won_d   = 1'b1;
                                state_d = S_WIN;
                            end else begin
                                round_len_d = round_len + IDX_W'(1);
                                idx_d       = '0;
                                pre_gap_d   = 1'b1;
                                state_d     = S_PLAY_GAP;
                            end
                        end
                    end else if (to_done) begin
                        miss_d  = 1'b1;
                        state_d = S_FAIL;
                    end
                end
                S_FAIL: begin
                    if (gap_done) begin
                        if (strict) begin
                            round_len_d = IDX_W'(START_LEN);
                            score_d     = '0;
                        end
                        idx_d   = '0;
                        state_d = S_PLAY_ON;
                    end
                end
                S_WIN: begin
                    if (start) begin
                        round_len_d = IDX_W'(START_LEN);
                        score_d     = '0;
                        idx_d       = '0;
                        state_d     = S_PLAY_ON;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output values are computed from the next state so they register in step with it.
    always_comb begin
        note_d   = '0;
        active_d = 1'b0;
        if (state_d == S_PLAY_ON) begin
            note_d   = mem[idx_d[AW-1:0]];
            active_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note_out    <= '0;
            note_active <= 1'b0;
            miss        <= 1'b0;
            round_pass  <= 1'b0;
            game_won    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            note_out    <= note_d;
            note_active <= active_d;
            miss        <= miss_d;
            round_pass  <= pass_d;
            game_won    <= won_d;
            busy        <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_melody_recall_engine.sv
// Directed bench for melody_recall_engine with a small, fast tick configuration.
module tb_melody_recall_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load_valid = 1'b0;
    logic [3:0] load_data = '0;
    logic       seq_clear = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       strict = 1'b0;
    logic       ans_valid = 1'b0;
    logic [3:0] ans_data = '0;
    logic [3:0] note_out;
    logic       note_active;
    logic [2:0] seq_len, round_len;
    logic [7:0] score;
    logic [2:0] state_out;
    logic       miss, round_pass, game_won, busy;

    int n_checks = 0;
    int n_errors = 0;
    int melody [4] = '{3, 5, 7, 9};
    int len;

    melody_recall_engine #(
        .NOTE_W(4), .MAX_NOTES(4), .START_LEN(2), .TICK_DIV(4),
        .ON_TICKS(2), .GAP_TICKS(1), .TIMEOUT_TICKS(3)
    ) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .seq_clear(seq_clear), .start(start), .abort(abort), .strict(strict),
        .ans_valid(ans_valid), .ans_data(ans_data), .note_out(note_out),
        .note_active(note_active), .seq_len(seq_len), .round_len(round_len),
        .score(score), .state_out(state_out), .miss(miss), .round_pass(round_pass),
        .game_won(game_won), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input int v);
        load_valid = 1'b1;
        load_data  = 4'(v);
        step();
        load_valid = 1'b0;
    endtask

    task automatic answer(input int v);
        ans_valid = 1'b1;
        ans_data  = 4'(v);
        step();
        ans_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Counts consecutive sampled cycles spent in state st, bounded.
    task automatic run_len(input int st, output int n);
        n = 0;
        while (state_out == 3'(st) && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic play_round(input int n);
        int l;
        for (int i = 0; i < n; i++) begin
            check("play_note", note_out, melody[i]);
            check("play_active", note_active, 1);
            run_len(1, l);
            check("play_on_len", l, 8);
            check("gap_note", note_out, 0);
            run_len(2, l);
            check("gap_len", l, 4);
        end
        check("wait_state", state_out, 3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        check("rst_state", state_out, 0);
        check("rst_seq_len", seq_len, 0);
        check("rst_round_len", round_len, 2);
        check("rst_score", score, 0);
        check("rst_note", note_out, 0);
        check("rst_busy", busy, 0);
        check("rst_miss", miss, 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 4; i++) load(melody[i]);
        check("seq_len_4", seq_len, 4);
        load(2);
        check("overflow_seq_len", seq_len, 4);

        pulse_start();
        check("start_state", state_out, 1);
        check("start_busy", busy, 1);
        play_round(2);

        answer(3);
        check("partial_no_pass", round_pass, 0);
        answer(5);
        check("pass_pulse", round_pass, 1);
        check("pass_score", score, 1);
        check("pass_round_len", round_len, 3);
        check("pass_to_gap", state_out, 2);
        run_len(2, len);
        check("lead_gap_len", len, 4);
        check("pass_pulse_low", round_pass, 0);
        play_round(3);

        answer(3);
        answer(4);
        check("miss_pulse", miss, 1);
        check("miss_state", state_out, 4);
        step();
        check("miss_pulse_low", miss, 0);
        run_len(4, len);
        check("fail_len_rest", len, 3);
        check("lax_round_len", round_len, 3);
        check("lax_score", score, 1);
        play_round(3);

        strict = 1'b1;
        answer(3);
        answer(4);
        check("strict_miss", miss, 1);
        run_len(4, len);
        check("strict_fail_len", len, 4);
        check("strict_round_len", round_len, 2);
        check("strict_score", score, 0);
        strict = 1'b0;
        play_round(2);

        run_len(3, len);
        check("timeout_len", len, 12);
        check("timeout_miss", miss, 1);
        check("timeout_state", state_out, 4);
        run_len(4, len);
        check("timeout_fail_len", len, 4);
        play_round(2);

        answer(3); answer(5);
        check("r2_score", score, 1);
        run_len(2, len);
        play_round(3);
        answer(3); answer(5); answer(7);
        check("r3_score", score, 2);
        check("r3_round_len", round_len, 4);
        run_len(2, len);
        play_round(4);
        answer(3); answer(5); answer(7);
        check("no_early_win", game_won, 0);
        answer(9);
        check("win_pulse", game_won, 1);
        check("win_pass", round_pass, 1);
        check("win_score", score, 3);
        check("win_state", state_out, 5);
        step();
        check("win_pulse_low", game_won, 0);
        check("win_hold", state_out, 5);
        pulse_start();
        check("restart_state", state_out, 1);
        check("restart_round_len", round_len, 2);
        check("restart_score", score, 0);

        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_state", state_out, 0);
        check("abort_note", note_out, 0);
        check("abort_busy", busy, 0);
        check("abort_seq_len", seq_len, 4);

        seq_clear = 1'b1;
        load_valid = 1'b1;
        load_data = 4'd6;
        step();
        seq_clear = 1'b0;
        load_valid = 1'b0;
        check("clear_wins", seq_len, 0);
        load(0);
        check("zero_ignored", seq_len, 0);
        load(3);
        check("one_note", seq_len, 1);
        pulse_start();
        check("short_start_ignored", state_out, 0);

        load(5); load(7);
        check("reload_len", seq_len, 3);
        pulse_start();
        repeat (2) step();
        check("pre_reset_note", note_out, 3);
        reset = 1'b1;
        #1;
        check("areset_state", state_out, 0);
        check("areset_note", note_out, 0);
        check("areset_active", note_active, 0);
        check("areset_seq_len", seq_len, 0);
        check("areset_round_len", round_len, 2);
        check("areset_busy", busy, 0);
        step();
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
